frame_diff_sequencer: RTL

- Scans a selected source frame against the reference frame, one memory word per cycle, through the Memory block's processing and reference read ports.
- Writes a difference-masked frame into the output frame through Memory's write port, and counts differing pixels.
- Sits between the top-level control logic and Memory. It drives frameSelProc, readAddressProc, readAddressRef, writeAddress, pixelIn and writeEn.

---
 rtl/frame_diff_sequencer_pkg.sv | 12 +
 rtl/frame_diff_sequencer_mask.sv | 21 ++
 rtl/frame_diff_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/frame_diff_sequencer_pkg.sv
// frame_diff_sequencer_pkg: shared FSM states, frame select codes and default widths.
package frame_diff_sequencer_pkg;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_PIX_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
  localparam logic [2:0] FRAME_RED_DROP = 3'd0;
  localparam logic [2:0] FRAME_BLUE_DROP = 3'd1;
  localparam logic [2:0] FRAME_BOTH_DROP = 3'd2;
  localparam logic [2:0] FRAME_REF = 3'd4;
  localparam logic [2:0] FRAME_OUT = 3'd5;
endpackage

// File: rtl/frame_diff_sequencer_mask.sv
// pixel_diff_mask: keeps source pixels that differ from the reference and counts them.
module pixel_diff_mask #(
  parameter int DATA_W = 128,
  parameter int PIX_W = 8,
  parameter int CNT_W = $clog2(DATA_W / PIX_W + 1)
) (
  input  logic [DATA_W-1:0] proc_i,
  input  logic [DATA_W-1:0] ref_i,
  output logic [DATA_W-1:0] mask_o,
  output logic [CNT_W-1:0]  cnt_o
);
  localparam int NPIX = DATA_W / PIX_W;
  always_comb begin
    mask_o = '0;
    cnt_o = '0;
    for (int i = 0; i < NPIX; i++) begin
      mask_o[i*PIX_W +: PIX_W] = (proc_i[i*PIX_W +: PIX_W] != ref_i[i*PIX_W +: PIX_W]) ? proc_i[i*PIX_W +: PIX_W] : '0;
      cnt_o = cnt_o + CNT_W'(proc_i[i*PIX_W +: PIX_W] != ref_i[i*PIX_W +: PIX_W]);
    end
  end
endmodule

// File: rtl/frame_diff_sequencer.sv
// frame_diff_sequencer: scans a source frame against the reference frame,
// writes the difference-masked frame and counts differing pixels.
module frame_diff_sequencer import frame_diff_sequencer_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int WORDS = 8192,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_W = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         frameSel,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] diffCount,
  output logic [2:0]         frameSelProc,
  output logic [ADDR_W-1:0]  readAddressProc,
  output logic [ADDR_W-1:0]  readAddressRef,
  input  logic [DATA_W-1:0]  pixelOutProc,
  input  logic [DATA_W-1:0]  pixelOutRef,
  output logic [ADDR_W-1:0]  writeAddress,
  output logic [DATA_W-1:0]  pixelIn,
  output logic               writeEn
);
  localparam int MCNT_W = $clog2(DATA_W / PIX_W + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [2:0] fsel_q;
  logic [COUNT_W-1:0] diff_q, diff_d;
  logic [READ_LATENCY-1:0] tv_q;
  logic [ADDR_W-1:0] ta_q [READ_LATENCY];
  logic we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q, mask;
  logic [MCNT_W-1:0] mcnt;
  logic [COUNT_W:0] sum;
  logic accept, kill, issue, emit;
  pixel_diff_mask #(.DATA_W(DATA_W), .PIX_W(PIX_W), .CNT_W(MCNT_W)) u_mask (
    .proc_i(pixelOutProc),
    .ref_i (pixelOutRef),
    .mask_o(mask),
    .cnt_o (mcnt)
  );
  assign accept = state_q == IDLE && start && !abort;
  assign kill = abort && (state_q == READ || state_q == DRAIN);
  assign issue = state_q == READ && !abort;
  assign emit = tv_q[READ_LATENCY-1] && !kill;
  // saturating accumulate of the emerging word's mismatch count
  assign sum = {1'b0, diff_q} + (COUNT_W + 1)'(mcnt);
  assign diff_d = sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? READ : IDLE;
      READ:    state_d = abort ? IDLE : (cnt_q == LAST ? DRAIN : READ);
      DRAIN:   state_d = abort ? IDLE : (|tv_q ? DRAIN : DONE);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fsel_q <= '0;
      diff_q <= '0;
      tv_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) ta_q[i] <= '0;
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      tv_q[0] <= issue;
      ta_q[0] <= cnt_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tv_q[i] <= tv_q[i-1] && !kill;
        ta_q[i] <= ta_q[i-1];
      end
      we_q <= emit;
      if (emit) begin
        wa_q <= ta_q[READ_LATENCY-1];
        wd_q <= mask;
      end
      if (accept) begin
        fsel_q <= frameSel;
        cnt_q <= '0;
        diff_q <= '0;
      end else begin
        if (state_q == READ && cnt_q != LAST) cnt_q <= cnt_q + ADDR_W'(1);
        if (emit) diff_q <= diff_d;
      end
    end
  assign busy = state_q == READ || state_q == DRAIN;
  assign done = state_q == DONE;
  assign diffCount = diff_q;
  assign frameSelProc = fsel_q;
  assign readAddressProc = cnt_q;
  assign readAddressRef = cnt_q;
  assign writeAddress = wa_q;
  assign pixelIn = wd_q;
  assign writeEn = we_q;
endmodule
